// File: rtl/alu_seq.sv
// Sequential 32-bit ALU: single-cycle logic/arith ops, 32-cycle shift-add multiply
// and (when ALU_SEQ_DIV_EN is defined) a 32-cycle restoring divider.
//
//   state  | meaning
//   S_IDLE | waiting for start; result/zero/err hold the last outcome
//   S_EXEC | operation in flight (1 cycle, or 32 for mul/div)
//   S_DONE | one-cycle result-valid pulse
module alu_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  sel,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        zero,
   output logic        err
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_sel;
   logic [31:0] r_a;       // operand A; multiplicand for mul, quotient for div
   logic [31:0] r_b;       // operand B; multiplier for mul, divisor for div
   logic [31:0] r_acc;     // product accumulator or partial remainder
   logic [4:0]  r_cnt;
   logic [31:0] r_result;
   logic        r_zero;
   logic        r_err;

   logic        w_is_mul;
   logic        w_is_div;
   logic        w_multi;
   logic        w_last;
   logic [31:0] w_mul_acc;
   logic [31:0] w_res;
   logic        w_err;

   assign w_is_mul  = (r_sel == 4'b0010);
   assign w_mul_acc = r_b[0] ? (r_acc + r_a) : r_acc;

`ifdef ALU_SEQ_DIV_EN
   logic [32:0] w_rem_sh;
   logic [32:0] w_diff;
   logic [31:0] w_rem_nxt;
   logic [31:0] w_quo_nxt;

   assign w_is_div  = (r_sel == 4'b0011);
   assign w_rem_sh  = {r_acc, r_a[31]};
   assign w_diff    = w_rem_sh - {1'b0, r_b};
   assign w_rem_nxt = w_diff[32] ? w_rem_sh[31:0] : w_diff[31:0];
   assign w_quo_nxt = {r_a[30:0], ~w_diff[32]};
`else
   assign w_is_div  = 1'b0;
`endif

   assign w_multi = w_is_mul | w_is_div;
   assign w_last  = w_multi ? (r_cnt == 5'd0) : 1'b1;

   // Final value as seen on the last EXEC cycle, including that cycle's iteration
   always_comb begin
      w_res = 32'd0;
      w_err = 1'b0;
      case (r_sel)
         4'b0000: w_res = r_a + r_b;
         4'b0001: w_res = r_a - r_b;
         4'b0010: w_res = w_mul_acc;
`ifdef ALU_SEQ_DIV_EN
         4'b0011: begin
            if (r_b == 32'd0) begin
               w_res = 32'hFFFF_FFFF;
               w_err = 1'b1;
            end else begin
               w_res = w_quo_nxt;
            end
         end
`endif
         4'b0100: w_res = r_a & r_b;
         4'b0101: w_res = r_a | r_b;
         4'b0110: w_res = r_a ^ r_b;
         4'b0111: w_res = ~r_a;
         4'b1000: w_res = {31'd0, ($signed(r_a) < $signed(r_b))};
         default: w_err = 1'b1;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b1;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) w_state_nxt = S_EXEC;
         end
         S_EXEC: if (w_last) w_state_nxt = S_DONE;
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel    <= 4'd0;
         r_a      <= 32'd0;
         r_b      <= 32'd0;
         r_acc    <= 32'd0;
         r_cnt    <= 5'd0;
         r_result <= 32'd0;
         r_zero   <= 1'b1;
         r_err    <= 1'b0;
      end else if (r_state == S_IDLE) begin
         if (start) begin
            r_sel <= sel;
            r_a   <= a;
            r_b   <= b;
            r_acc <= 32'd0;
            r_cnt <= 5'd31;
         end
      end else if (r_state == S_EXEC) begin
         if (w_is_mul) begin
            r_acc <= w_mul_acc;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
         end
`ifdef ALU_SEQ_DIV_EN
         if (w_is_div) begin
            r_acc <= w_rem_nxt;
            r_a   <= w_quo_nxt;
         end
`endif
         if (w_multi) r_cnt <= r_cnt - 5'd1;
         if (w_last) begin
            r_result <= w_res;
            r_zero   <= (w_res == 32'd0);
            r_err    <= w_err;
         end
      end
   end

   assign result = r_result;
   assign zero   = r_zero;
   assign err    = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases plus random ops against an
// arithmetic reference model. Honours ALU_SEQ_DIV_EN for divide expectations.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  sel;
   logic [31:0] a;
   logic [31:0] b;
   logic        start;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        zero;
   logic        err;

   int n_checks = 0;
   int n_fails  = 0;

   alu_seq dut (
      .clk    (clk),
      .rst    (rst),
      .sel    (sel),
      .a      (a),
      .b      (b),
      .start  (start),
      .busy   (busy),
      .done   (done),
      .result (result),
      .zero   (zero),
      .err    (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: result, err and cycle at which done is seen (accept edge = cycle 0)
   task automatic model(input logic [3:0] s, input logic [31:0] oa, input logic [31:0] ob,
                        output logic [31:0] er, output logic ee, output int lat);
      er  = 32'd0;
      ee  = 1'b0;
      lat = 2;
      case (s)
         4'd0: er = oa + ob;
         4'd1: er = oa - ob;
         4'd2: begin er = oa * ob; lat = 33; end
         4'd3: begin
`ifdef ALU_SEQ_DIV_EN
            lat = 33;
            if (ob == 0) begin er = 32'hFFFF_FFFF; ee = 1'b1; end
            else er = oa / ob;
`else
            ee = 1'b1;
`endif
         end
         4'd4: er = oa & ob;
         4'd5: er = oa | ob;
         4'd6: er = oa ^ ob;
         4'd7: er = ~oa;
         4'd8: er = ($signed(oa) < $signed(ob)) ? 32'd1 : 32'd0;
         default: ee = 1'b1;
      endcase
   endtask

   // Runs one op; poke > 0 pulses start with fresh operands in that cycle of the op
   task automatic run_op(input string tag, input logic [3:0] s, input logic [31:0] oa,
                         input logic [31:0] ob, input int poke);
      logic [31:0] er;
      logic        ee;
      int          el;
      int          cyc;
      int          nbusy;
      model(s, oa, ob, er, ee, el);
      @(negedge clk);
      sel = s; a = oa; b = ob; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      sel = 4'($urandom); a = $urandom; b = $urandom;
      cyc = 1; nbusy = 0;
      while (!done && cyc < 45) begin
         if (busy) nbusy++;
         start = (cyc == poke);
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      if (busy) nbusy++;
      check({tag, " latency"}, cyc, el);
      check({tag, " busy_cycles"}, nbusy, el);
      check({tag, " result"}, result, er);
      check({tag, " zero"}, {31'd0, zero}, {31'd0, (er == 32'd0)});
      check({tag, " err"}, {31'd0, err}, {31'd0, ee});
      @(posedge clk); #1;
      check({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
      check({tag, " idle_done"}, {31'd0, done}, 32'd0);
      check({tag, " held_result"}, result, er);
   endtask

   initial begin
      int seen_done;
      logic [3:0] rs;
      logic [31:0] ra;
      logic [31:0] rb;
      rst = 1'b1; start = 1'b0; sel = 4'd0; a = 32'd0; b = 32'd0;
      #12;
      check("rst busy",   {31'd0, busy}, 32'd0);
      check("rst done",   {31'd0, done}, 32'd0);
      check("rst result", result, 32'd0);
      check("rst zero",   {31'd0, zero}, 32'd1);
      check("rst err",    {31'd0, err},  32'd0);
      @(negedge clk); rst = 1'b0;

      run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 0);
      run_op("sub_neg",  4'd1, 32'd5, 32'd7, 0);
      run_op("mul_dir",  4'd2, 32'h0001_0000, 32'h0001_0001, 0);
      run_op("div_dir",  4'd3, 32'd100, 32'd7, 0);
      run_op("div_zero", 4'd3, 32'd9, 32'd0, 0);
      run_op("slt_neg",  4'd8, 32'hFFFF_FFFF, 32'd1, 0);
      run_op("slt_pos",  4'd8, 32'd1, 32'hFFFF_FFFF, 0);
      run_op("bad_sel",  4'd10, 32'h1234_5678, 32'h9ABC_DEF0, 0);
      run_op("not_op",   4'd7, 32'h0F0F_0000, 32'hFFFF_FFFF, 0);
      run_op("mul_poke", 4'd2, 32'h0000_1234, 32'h0000_5678, 5);

      // Reset in the middle of a multiply: no done, outputs return to reset values
      @(negedge clk);
      sel = 4'd2; a = $urandom; b = $urandom; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      check("midrst busy",   {31'd0, busy}, 32'd0);
      check("midrst done",   {31'd0, done}, 32'd0);
      check("midrst result", result, 32'd0);
      check("midrst zero",   {31'd0, zero}, 32'd1);
      check("midrst err",    {31'd0, err},  32'd0);
      @(negedge clk); rst = 1'b0;
      seen_done = 0;
      repeat (40) begin @(posedge clk); #1; if (done) seen_done++; end
      check("midrst no_done", seen_done, 0);
      run_op("post_rst_add", 4'd0, 32'd40, 32'd2, 0);

      for (int i = 0; i < 25; i++) begin
         rs = 4'($urandom_range(0, 15));
         ra = $urandom;
         rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 28);
         run_op("rand", rs, ra, rb, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #2_000_000;
      n_fails++;
      $display("FAIL watchdog: observed timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $fatal(1, "watchdog expired");
   end

endmodule
